packet_uart_tx: RTL
===================

// Module: packet_uart_tx
//
// PURPOSE
//  Transmit side of the pong command-packet link. Accepts payload bytes over a
//  valid/ready handshake and frames each one as a 2-byte packet: HEADER_BYTE,
//  then the payload byte. Each byte is serialised 8N1, LSB first, on o_uart_tx.
//  This is the peer of the packet receiver/aggregator: same header, framing and
//  i_setup baud format, so a loopback wire recovers every payload byte.
//
// PARAMETERS
//  HEADER_BYTE   8'hF5   first byte of every packet
//  MIN_CLKS      24'd2   floor applied to clocks-per-bit from i_setup
//
// PORTS
//  i_clk       in   1   system clock
//  n_btn_rst   in   1   reset: asynchronous, active-low
//  i_setup     in   31  baud config. [23:0] = clocks per bit; [30:24] reserved, write 0
//  i_valid     in   1   i_data holds a payload byte to send
//  i_data      in   8   payload byte
//  o_ready     out  1   holding register empty; transfer when i_valid && o_ready
//  o_busy      out  1   packet on the wire, or holding register full
//  o_uart_tx   out  1   serial line, idle high
//
// BEHAVIOUR
//  - Reset, async, all registered: o_uart_tx=1, o_ready=1, o_busy=0. FSM=IDLE,
//    holding register empty, counters=0. Reset mid-packet aborts the packet at
//    once (line high) and discards held data. No partial byte resumes.
//  - Buffering: one holding register plus one active packet. At most 2 payloads
//    are accepted but not yet sent. o_ready = !hold_full (registered).
//  - Accept at edge N in IDLE:
//      * payload goes into the active packet;
//      * o_uart_tx=0 (header start bit) from edge N+1;
//      * o_busy=1 from edge N+1.
//  - Accept while active: payload goes to holding; o_ready=0 from edge N+1.
//  - Bit time: T = max(i_setup[23:0], MIN_CLKS) clocks. T is latched at packet
//    start, i.e. on the edge the header start bit begins.
//  - i_setup changes mid-packet take effect on the next packet only.
//  - FSM states and transitions:
//      * IDLE: load packet when active data exists -> START.
//      * START: 1 bit time of 0 -> DATA.
//      * DATA: 8 bit times, bit_idx 0..7, LSB first -> STOP.
//      * STOP: 1 bit time of 1. Then:
//          - byte_idx=0: byte_idx=1 -> START (payload byte);
//          - byte_idx=1, hold full: move hold to active, clear hold,
//            o_ready=1, latch T -> START (next packet);
//          - otherwise -> IDLE.
//  - Gaps: none between header and payload, and none between back-to-back
//    packets. A packet is exactly 20*T clocks.
//  - Bit counter: counts T-1 down to 0, and the state advances on 0.
//  - o_busy=0 only in IDLE with hold empty. It falls on the edge the final
//    stop bit ends.
//  - Payload equal to HEADER_BYTE is sent unescaped (receiver syncs on first F5).
//  - i_data is sampled only on the accept edge. It is don't-care otherwise.
//
// TESTING
//  1 Reset held, then released -> o_uart_tx=1, o_ready=1, o_busy=0. Line stays
//    high 1000 clks with i_valid=0.
//  2 i_setup=4, send 0x32 -> 80 clks total, each bit 4 clks:
//      * header: 0, 1,0,1,0,1,1,1,1, 1;
//      * payload: 0, 0,1,0,0,1,1,0,0, 1;
//      * o_busy drops at clk 80.
//  3 i_setup=4, i_valid held with 0x11, 0x22, 0x33:
//      * 0x11 and 0x22 accepted on consecutive edges; o_ready=0;
//      * 0x33 accepted 1 clk after the 0x11 packet ends;
//      * 3 contiguous packets, 240 clks, no idle gap.
//  4 Loopback into the receiver, i_setup=104:
//      * send 0x00, 0xF5, 0xFF, 0x5A;
//      * the receiver outputs exactly those 4 bytes, in order.
//  5 Assert n_btn_rst at clk 50 of a packet with hold full:
//      * o_uart_tx=1 and o_ready=1 asynchronously;
//      * nothing more is transmitted until the next i_valid.
//  6 Clamp and latch: i_setup=1 gives 2-clk bits (40-clk packet).
//    Changing i_setup 4->8 at clk 30 leaves that packet at 80 clks and the
//    next at 160 clks.

Source files
------------

// File: rtl/packet_uart_tx_if.sv
// Payload byte handshake into the packet UART transmitter.
// Latency: n/a (wires only).
// Backpressure: transfer when i_valid && o_ready on a clock edge.
interface packet_uart_tx_if;
    logic       i_valid;
    logic [7:0] i_data;
    logic       o_ready;

    modport master (output i_valid, output i_data, input o_ready);
    modport slave  (input i_valid, input i_data, output o_ready);
endinterface

// File: rtl/packet_uart_tx.sv
// Frames each payload byte as {HEADER_BYTE, payload} and serialises both bytes 8N1, LSB first.
// Latency: header start bit begins one edge after the accept edge; a packet lasts 20*T clocks.
// Backpressure: one holding register plus the active packet; o_ready drops while the holding register is full.
module packet_uart_tx #(
    parameter logic [7:0]  HEADER_BYTE = 8'hF5,
    parameter logic [23:0] MIN_CLKS    = 24'd2
) (
    input  logic              i_clk,
    input  logic              n_btn_rst,
    input  logic [30:0]       i_setup,
    packet_uart_tx_if.slave   s_if,
    output logic              o_busy,
    output logic              o_uart_tx
);

    typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} state_t;

    state_t      state_q, state_d;
    logic [23:0] t_q, t_d;
    logic [23:0] cnt_q, cnt_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic        byte_idx_q, byte_idx_d;
    logic [7:0]  act_q, act_d;
    logic        act_full_q, act_full_d;
    logic [7:0]  hold_q, hold_d;
    logic        hold_full_q, hold_full_d;
    logic        ready_q, ready_d;
    logic        busy_q, busy_d;
    logic        tx_q, tx_d;

    logic [23:0] t_setup;
    logic        acc;
    logic        finishing;
    logic [7:0]  cur_byte;

    // Reserved configuration bits carry no function.
    logic unused_setup;
    assign unused_setup = ^i_setup[30:24];

    // Clocks per bit from the configuration, floored so the counter never underflows.
    assign t_setup = (i_setup[23:0] < MIN_CLKS) ? MIN_CLKS : i_setup[23:0];
    assign acc     = s_if.i_valid && ready_q;

    assign s_if.o_ready = ready_q;
    assign o_busy       = busy_q;
    assign o_uart_tx    = tx_q;

    // State and datapath registers; reset aborts any packet and drops held data.
    always_ff @(posedge i_clk or negedge n_btn_rst) begin
        if (!n_btn_rst) begin
            state_q     <= ST_IDLE;
            t_q         <= '0;
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            byte_idx_q  <= 1'b0;
            act_q       <= '0;
            act_full_q  <= 1'b0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            ready_q     <= 1'b1;
            busy_q      <= 1'b0;
            tx_q        <= 1'b1;
        end else begin
            state_q     <= state_d;
            t_q         <= t_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            byte_idx_q  <= byte_idx_d;
            act_q       <= act_d;
            act_full_q  <= act_full_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            ready_q     <= ready_d;
            busy_q      <= busy_d;
            tx_q        <= tx_d;
        end
    end

    // Next state: bit timing, byte sequencing and routing of accepted payloads.
    always_comb begin
        state_d     = state_q;
        t_d         = t_q;
        cnt_d       = cnt_q;
        bit_idx_d   = bit_idx_q;
        byte_idx_d  = byte_idx_q;
        act_d       = act_q;
        act_full_d  = act_full_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        finishing   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (act_full_q) begin
                    state_d    = ST_START;
                    t_d        = t_setup;
                    cnt_d      = t_setup - 24'd1;
                    byte_idx_d = 1'b0;
                end
            end
            ST_START: begin
                if (cnt_q == '0) begin
                    state_d   = ST_DATA;
                    bit_idx_d = 3'd0;
                    cnt_d     = t_q - 24'd1;
                end else begin
                    cnt_d = cnt_q - 24'd1;
                end
            end
            ST_DATA: begin
                if (cnt_q == '0) begin
                    cnt_d = t_q - 24'd1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = ST_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q - 24'd1;
                end
            end
            ST_STOP: begin
                if (cnt_q == '0) begin
                    if (!byte_idx_q) begin
                        byte_idx_d = 1'b1;
                        state_d    = ST_START;
                        cnt_d      = t_q - 24'd1;
                    end else if (hold_full_q) begin
                        // Back-to-back packet: promote the held byte, fresh bit time.
                        act_d       = hold_q;
                        hold_full_d = 1'b0;
                        t_d         = t_setup;
                        cnt_d       = t_setup - 24'd1;
                        byte_idx_d  = 1'b0;
                        state_d     = ST_START;
                    end else begin
                        act_full_d = 1'b0;
                        finishing  = 1'b1;
                        state_d    = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - 24'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // An accepted byte fills the active slot when it is free, else the holding register.
        if (acc) begin
            if (!act_full_q || finishing) begin
                act_d      = s_if.i_data;
                act_full_d = 1'b1;
            end else begin
                hold_d      = s_if.i_data;
                hold_full_d = 1'b1;
            end
        end
    end

    // Registered outputs derived from the next state so they change on the same edge.
    always_comb begin
        cur_byte = byte_idx_d ? act_d : HEADER_BYTE;
        case (state_d)
            ST_START: tx_d = 1'b0;
            ST_DATA:  tx_d = cur_byte[bit_idx_d];
            default:  tx_d = 1'b1;
        endcase
        busy_d  = !((state_d == ST_IDLE) && !hold_full_d);
        ready_d = !hold_full_d;
    end

endmodule
